conbus_rr_arbiter: RTL

Round-robin Wishbone arbiter that lets NM bus masters share one slave-side Wishbone bus in the conbus interconnect. A master holds the bus from grant until it drops `cyc`. A per-transfer watchdog aborts any `stb` left unacknowledged too long and returns `err` to the owning master. The block sits between the CPU/DMA masters and the conbus address decoder.

---
 rtl/conbus_pkg.sv | 24 ++
 rtl/conbus_rr_pick.sv | 31 +++
 rtl/conbus_rr_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/conbus_pkg.sv
// Shared types and constants for the conbus round-robin arbiter.
// Holds the arbiter state encoding, watchdog width and a one-hot decode helper.
package conbus_pkg;

    localparam int WD_W   = 16;
    localparam int NM_MAX = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWNED = 2'd1,
        ST_ABORT = 2'd2
    } conbus_state_e;

    // One-hot to binary index; an all-zero vector decodes to index 0.
    function automatic logic [2:0] oh2idx(input logic [NM_MAX-1:0] oh);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < NM_MAX; i++) begin
            r = r | (oh[i] ? 3'(i) : 3'd0);
        end
        return r;
    endfunction

endpackage

// File: rtl/conbus_rr_pick.sv
// Rotating-priority encoder: the first requester after last_i (wrapping,
// last_i itself checked last) wins.
module conbus_rr_pick #(
    parameter int NM = 4,
    localparam int IW = $clog2(NM)
) (
    input  logic [NM-1:0] req_i,
    input  logic [IW-1:0] last_i,
    output logic [NM-1:0] win_o,
    output logic          valid_o
);

    logic [IW-1:0] idx_s;

    // Walk the wrap-around search order, latching the first hit.
    always_comb begin
        win_o   = '0;
        valid_o = 1'b0;
        idx_s   = '0;
        for (int i = 1; i <= NM; i++) begin
            idx_s = IW'((int'(last_i) + i) % NM);
            if (!valid_o && req_i[idx_s]) begin
                win_o[idx_s] = 1'b1;
                valid_o      = 1'b1;
            end else begin
                valid_o = valid_o;
            end
        end
    end

endmodule

// File: rtl/conbus_rr_arbiter.sv
// Round-robin Wishbone arbiter: NM masters share one slave bus, ownership
// lasts until the owner drops cyc, with a per-strobe watchdog abort.
module conbus_rr_arbiter
    import conbus_pkg::*;
#(
    parameter int NM      = 4,
    parameter int TIMEOUT = 255
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [NM*32-1:0]   m_adr_i,
    input  logic [NM*32-1:0]   m_dat_i,
    input  logic [NM*3-1:0]    m_cti_i,
    input  logic [NM-1:0]      m_we_i,
    input  logic [NM*4-1:0]    m_sel_i,
    input  logic [NM-1:0]      m_cyc_i,
    input  logic [NM-1:0]      m_stb_i,
    output logic [31:0]        m_dat_o,
    output logic [NM-1:0]      m_ack_o,
    output logic [NM-1:0]      m_err_o,
    output logic [31:0]        s_adr_o,
    output logic [31:0]        s_dat_o,
    output logic [2:0]         s_cti_o,
    output logic               s_we_o,
    output logic [3:0]         s_sel_o,
    output logic               s_cyc_o,
    output logic               s_stb_o,
    input  logic [31:0]        s_dat_i,
    input  logic               s_ack_i,
    output logic [NM-1:0]      gnt_o,
    output logic               timeout_o
);

    localparam int IW = $clog2(NM);
    localparam logic [WD_W-1:0] TMO_C = WD_W'(TIMEOUT);

    conbus_state_e   state_q, state_d;
    logic [NM-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]   last_q, last_d;
    logic [WD_W-1:0] cnt_q, cnt_d;

    logic [NM-1:0]   pick_win_s;
    logic            pick_valid_s;
    logic [IW-1:0]   pick_idx_s;
    logic [IW-1:0]   own_idx_s;
    logic            own_cyc_s;
    logic            own_stb_s;
    logic            owned_s;
    logic            tmo_hit_s;

    conbus_rr_pick #(.NM(NM)) u_pick (
        .req_i   (m_cyc_i),
        .last_i  (last_q),
        .win_o   (pick_win_s),
        .valid_o (pick_valid_s)
    );

    assign pick_idx_s = IW'(oh2idx(NM_MAX'(pick_win_s)));
    assign own_idx_s  = IW'(oh2idx(NM_MAX'(gnt_q)));
    assign own_cyc_s  = m_cyc_i[own_idx_s];
    assign own_stb_s  = m_stb_i[own_idx_s];
    // Reset low masks the slave side and all responses within the same cycle.
    assign owned_s    = sys_rst_n & (state_q == ST_OWNED);
    // An ack landing on the limit cycle takes precedence over the abort.
    assign tmo_hit_s  = owned_s & own_cyc_s & own_stb_s & ~s_ack_i & (cnt_q == TMO_C);

    // State, grant, pointer and watchdog registers.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            last_q  <= IW'(NM - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: grant on request, re-arbitrate on release, abort on timeout.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_d = ST_OWNED;
                    gnt_d   = pick_win_s;
                    last_d  = pick_idx_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWNED, ST_ABORT: begin
                if (!own_cyc_s) begin
                    if (pick_valid_s) begin
                        state_d = ST_OWNED;
                        gnt_d   = pick_win_s;
                        last_d  = pick_idx_s;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                    end
                end else if (tmo_hit_s) begin
                    state_d = ST_ABORT;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase

        if ((gnt_d != gnt_q) || !s_stb_o || s_ack_i) begin
            cnt_d = '0;
        end else if (cnt_q != TMO_C) begin
            cnt_d = cnt_q + WD_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Outputs: slave-side mux of the owner and per-master response steering.
    always_comb begin
        m_ack_o   = '0;
        m_err_o   = '0;
        s_cyc_o   = owned_s & own_cyc_s & ~tmo_hit_s;
        s_stb_o   = owned_s & own_stb_s & ~tmo_hit_s;
        timeout_o = tmo_hit_s;
        if (owned_s) begin
            m_ack_o[own_idx_s] = s_ack_i;
        end else begin
            m_ack_o = '0;
        end
        if (tmo_hit_s) begin
            m_err_o[own_idx_s] = 1'b1;
        end else begin
            m_err_o = '0;
        end
    end

    assign m_dat_o = s_dat_i;
    assign s_adr_o = m_adr_i[int'(own_idx_s)*32 +: 32];
    assign s_dat_o = m_dat_i[int'(own_idx_s)*32 +: 32];
    assign s_cti_o = m_cti_i[int'(own_idx_s)*3 +: 3];
    assign s_sel_o = m_sel_i[int'(own_idx_s)*4 +: 4];
    assign s_we_o  = m_we_i[own_idx_s];
    assign gnt_o   = gnt_q;

endmodule
